register32_8_reader: RTL and testbench

REGISTER32_8_READER -- requirements
Module: register32_8_reader

---
 rtl/register32_8_pkg.sv | 21 ++
 rtl/fifo2_32.sv | 94 +++++++++
 rtl/register32_8_reader.sv | 86 ++++++++
 tb/tb_register32_8_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/register32_8_pkg.sv
// Shared parameters and types for the register32_8_reader slice.
package register32_8_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned NREG       = 8;
  localparam int unsigned FIFO_DEPTH = 2;

  // FIFO occupancy; the encoding equals the number of stored entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/fifo2_32.sv
// Two-entry data+tag FIFO with an EMPTY/ONE/FULL occupancy state machine.
// The head entry is always held in head_q; tail_q holds the second entry when FULL.
// Vacated slots are zeroed so the head reads as zero whenever the FIFO is empty.
module fifo2_32
  import register32_8_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_tag,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_tag
);

  occ_state_e  state_q, state_d;
  fifo_entry_t head_q, head_d;
  fifo_entry_t tail_q, tail_d;
  fifo_entry_t new_entry;
  logic        push_ok;
  logic        pop_ok;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  always_comb begin
    new_entry.data = push_data;
    new_entry.tag  = push_tag;
    push_ok        = push & (state_q != FULL);
    pop_ok         = pop & (state_q != EMPTY);
  end

  // Next-state and storage update for the occupancy machine.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push_ok) begin
          state_d = ONE;
          head_d  = new_entry;
        end
      end
      ONE: begin
        if (push_ok && pop_ok) begin
          // Head leaves and the new entry takes its place in the same edge.
          head_d = new_entry;
        end else if (push_ok) begin
          state_d = FULL;
          tail_d  = new_entry;
        end else if (pop_ok) begin
          state_d = EMPTY;
          head_d  = '0;
        end
      end
      FULL: begin
        if (pop_ok) begin
          state_d = ONE;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  // State and storage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Status and head outputs come straight from registers.
  always_comb begin
    full      = (state_q == FULL);
    empty     = (state_q == EMPTY);
    head_data = head_q.data;
    head_tag  = head_q.tag;
  end

endmodule

// File: rtl/register32_8_reader.sv
// Register-bank reader: 8:1 read mux into a 2-entry result FIFO, one-cycle latency.
// Optional write-through forwarding is enabled by defining REGISTER32_8_READER_BYPASS_EN;
// without it the pre-write register value is always returned.
module register32_8_reader
  import register32_8_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  input  logic [DATA_W-1:0] reg_in0,
  input  logic [DATA_W-1:0] reg_in1,
  input  logic [DATA_W-1:0] reg_in2,
  input  logic [DATA_W-1:0] reg_in3,
  input  logic [DATA_W-1:0] reg_in4,
  input  logic [DATA_W-1:0] reg_in5,
  input  logic [DATA_W-1:0] reg_in6,
  input  logic [DATA_W-1:0] reg_in7,
  input  logic [NREG-1:0]   wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_tag,
  input  logic              rd_accept
);

  logic [DATA_W-1:0] mux_data;
  logic [DATA_W-1:0] push_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // 8:1 read mux over the register bank.
  always_comb begin
    mux_data = '0;
    case (rd_addr)
      3'd0:    mux_data = reg_in0;
      3'd1:    mux_data = reg_in1;
      3'd2:    mux_data = reg_in2;
      3'd3:    mux_data = reg_in3;
      3'd4:    mux_data = reg_in4;
      3'd5:    mux_data = reg_in5;
      3'd6:    mux_data = reg_in6;
      default: mux_data = reg_in7;
    endcase
  end

`ifdef REGISTER32_8_READER_BYPASS_EN
  // Forward the in-flight write only when it targets the register being read.
  always_comb begin
    push_data = wr_en[rd_addr] ? wr_data : mux_data;
  end
`else
  logic unused_wr;

  // Write port is ignored; the register's current contents are returned.
  always_comb begin
    push_data = mux_data;
    unused_wr = ^{wr_en, wr_data};
  end
`endif

  // Handshakes; rd_ready depends only on registered FIFO state.
  always_comb begin
    rd_ready = ~fifo_full;
    rd_valid = ~fifo_empty;
    push     = rd_req & ~fifo_full;
    pop      = rd_accept & ~fifo_empty;
  end

  fifo2_32 u_fifo (
    .clk       (clk),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .push_tag  (rd_addr),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (rd_data),
    .head_tag  (rd_tag)
  );

endmodule

// File: tb/tb_register32_8_reader.sv
// Self-checking bench for register32_8_reader: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
// Compile with REGISTER32_8_READER_BYPASS_EN to exercise the forwarding build.
module tb_register32_8_reader;

  logic        clk = 1'b0;
  logic        clear;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ready;
  logic [31:0] regs [8];
  logic [7:0]  wr_en;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [2:0]  rd_tag;
  logic        rd_accept;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  t;
  } ent_t;
  ent_t model_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  register32_8_reader dut (
    .clk       (clk),
    .clear     (clear),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .reg_in0   (regs[0]),
    .reg_in1   (regs[1]),
    .reg_in2   (regs[2]),
    .reg_in3   (regs[3]),
    .reg_in4   (regs[4]),
    .reg_in5   (regs[5]),
    .reg_in6   (regs[6]),
    .reg_in7   (regs[7]),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_accept (rd_accept)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Value the block should capture for the current inputs.
  function automatic logic [31:0] expected_read(input logic [2:0] a);
`ifdef REGISTER32_8_READER_BYPASS_EN
    if (wr_en[a]) return wr_data;
`endif
    return regs[a];
  endfunction

  task automatic check_outputs(input string where);
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  et;
    ev = (model_q.size() != 0);
    ed = ev ? model_q[0].d : 32'h0;
    et = ev ? model_q[0].t : 3'h0;
    check({where, "_valid"}, 32'(rd_valid), 32'(ev));
    check({where, "_ready"}, 32'(rd_ready), 32'(model_q.size() < 2));
    check({where, "_data"}, rd_data, ed);
    check({where, "_tag"}, 32'(rd_tag), 32'(et));
  endtask

  // Reference behaviour at a rising edge: pop uses the old occupancy, push the old room.
  task automatic model_edge();
    bit   acc;
    bit   pop;
    ent_t e;
    acc = rd_req && (model_q.size() < 2);
    pop = rd_accept && (model_q.size() > 0);
    e.d = expected_read(rd_addr);
    e.t = rd_addr;
    if (pop) void'(model_q.pop_front());
    if (acc) model_q.push_back(e);
  endtask

  // One clock: check mid-cycle, advance the model at the edge, return 1 time unit later.
  task automatic cycle(input string where);
    @(negedge clk);
    check_outputs(where);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous clear pulse entirely between two edges.
  task automatic pulse_clear();
    #1 clear = 1'b1;
    #1;
    check("clr_valid", 32'(rd_valid), 32'h0);
    check("clr_ready", 32'(rd_ready), 32'h1);
    check("clr_data", rd_data, 32'h0);
    check("clr_tag", 32'(rd_tag), 32'h0);
    model_q.delete();
    #1 clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_byp;
    clear     = 1'b1;
    rd_req    = 1'b0;
    rd_addr   = 3'd0;
    rd_accept = 1'b0;
    wr_en     = 8'h0;
    wr_data   = 32'h0;
    for (int i = 0; i < 8; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    #1;
    check_outputs("reset");
    #1 clear = 1'b0;
    @(posedge clk);
    #1;

    // Basic read with one-cycle latency.
    regs[3]   = 32'hDEAD_BEEF;
    rd_req    = 1'b1;
    rd_addr   = 3'd3;
    rd_accept = 1'b1;
    cycle("basic_req");
    rd_req = 1'b0;
    check("basic_data", rd_data, 32'hDEAD_BEEF);
    check("basic_tag", 32'(rd_tag), 32'd3);
    cycle("basic_out");
    check("basic_after", 32'(rd_valid), 32'h0);

    // Backpressure: fill, ignored third request, ordered drain.
    rd_accept = 1'b0;
    rd_req    = 1'b1;
    rd_addr   = 3'd1;
    cycle("bp_a1");
    rd_addr = 3'd2;
    cycle("bp_a2");
    check("bp_full_ready", 32'(rd_ready), 32'h0);
    rd_addr = 3'd5;
    cycle("bp_a5");
    rd_req    = 1'b0;
    rd_accept = 1'b1;
    check("bp_first", rd_data, regs[1]);
    cycle("bp_pop1");
    check("bp_ready_back", 32'(rd_ready), 32'h1);
    check("bp_second", rd_data, regs[2]);
    cycle("bp_pop2");
    check("bp_empty", 32'(rd_valid), 32'h0);

    // Streaming: a request and a pop every cycle, no bubbles.
    rd_req    = 1'b1;
    rd_accept = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      cycle("stream");
      check("stream_data", rd_data, regs[i]);
      check("stream_ready", 32'(rd_ready), 32'h1);
    end
    rd_req = 1'b0;
    cycle("stream_drain");

    // Forwarding on a matching write enable, none on a different one.
    regs[6] = 32'h1111_1111;
    wr_data = 32'h2222_2222;
    wr_en   = 8'h40;
    rd_req  = 1'b1;
    rd_addr = 3'd6;
`ifdef REGISTER32_8_READER_BYPASS_EN
    exp_byp = 32'h2222_2222;
`else
    exp_byp = 32'h1111_1111;
`endif
    cycle("byp_hit");
    rd_req = 1'b0;
    wr_en  = 8'h00;
    check("byp_hit_data", rd_data, exp_byp);
    cycle("byp_drain1");
    wr_en  = 8'h01;
    rd_req = 1'b1;
    cycle("byp_miss");
    rd_req = 1'b0;
    wr_en  = 8'h00;
    check("byp_miss_data", rd_data, 32'h1111_1111);
    cycle("byp_drain2");

    // Clear while full: pending entries vanish.
    rd_accept = 1'b0;
    rd_req    = 1'b1;
    rd_addr   = 3'd4;
    cycle("rst_a4");
    rd_addr = 3'd7;
    cycle("rst_a7");
    rd_req    = 1'b0;
    rd_accept = 1'b1;
    pulse_clear();
    for (int i = 0; i < 3; i++) cycle("rst_idle");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rd_req    = ($urandom_range(0, 3) != 0);
      rd_addr   = 3'($urandom_range(0, 7));
      rd_accept = ($urandom_range(0, 2) != 0);
      wr_data   = $urandom;
      case ($urandom_range(0, 2))
        0:       wr_en = 8'h0;
        1:       wr_en = 8'(1 << rd_addr);
        default: wr_en = 8'(1 << $urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = $urandom;
      if ($urandom_range(0, 60) == 0) pulse_clear();
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
